// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_pkg                                                      |
// | Desc   : Shared constants and types for the SPI receive path.         |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package spi_pkg;

  // Native frame length of the SPI receiver.
  localparam int SPI_WORD_W = 16;

  // One received SPI word.
  typedef logic [SPI_WORD_W-1:0] spi_word_t;

  // Bit-counter width for a given frame length (at least one bit).
  function automatic int spi_cnt_w(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_shift_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_shift_in                                                 |
// | Desc   : Serial-in shift register and modulo-DATA_W bit counter.      |
// |          Flags the edge that completes a word and presents the       |
// |          completed word combinationally on that edge.                |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module spi_shift_in
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic [DATA_W-1:0] o_word,
  output logic              o_done
);

  localparam int              CNT_W    = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] w_shifted;
  logic              w_last;

  // Bit ordering: MSB-first shifts left into bit 0, LSB-first shifts right
  // into the top bit, so after DATA_W bits the first bit sits at the far end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {shift_q[DATA_W-2:0], i_mosi};
    end else begin : g_lsb_first
      assign w_shifted = {i_mosi, shift_q[DATA_W-1:1]};
    end
  endgenerate

  assign w_last = (cnt_q == c_last);

  // Next-state: shift and count while selected; clear count when deselected.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    o_done  = 1'b0;
    if (!i_cs_n) begin
      shift_d = w_shifted;
      o_done  = w_last;
      cnt_d   = w_last ? '0 : (cnt_q + c_one);
    end else begin
      cnt_d   = '0;
    end
  end

  assign o_word = w_shifted;

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : spi_shift_in
`default_nettype wire

// File: rtl/spi_rx16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_rx16                                                     |
// | Desc   : SPI slave receive-only deserialiser. Holds the last complete |
// |          word on spi_data; runs entirely on spi_clk.                 |
// |          Optional macro SPI_RX16_VALID_EN adds a one-cycle spi_valid |
// |          strobe on each completed word.                              |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module spi_rx16
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] spi_data
`ifdef SPI_RX16_VALID_EN
  ,
  output logic              spi_valid
`endif
);

  logic [DATA_W-1:0] w_word;
  logic              w_done;
  logic [DATA_W-1:0] spi_data_q, spi_data_d;

  spi_shift_in #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_in (
    .i_clk   (spi_clk),
    .i_reset (reset),
    .i_cs_n  (spi_cs),
    .i_mosi  (spi_mosi),
    .o_word  (w_word),
    .o_done  (w_done)
  );

  // Output word only moves on the completing edge; partial frames never leak.
  always_comb begin
    spi_data_d = spi_data_q;
    if (w_done) begin
      spi_data_d = w_word;
    end
  end

  // Output latch with asynchronous clear.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      spi_data_q <= '0;
    end else begin
      spi_data_q <= spi_data_d;
    end
  end

  assign spi_data = spi_data_q;

`ifdef SPI_RX16_VALID_EN
  logic spi_valid_q, spi_valid_d;

  // Strobe is the registered completion flag, so it lasts one spi_clk cycle.
  always_comb begin
    spi_valid_d = w_done;
  end

  // Valid strobe register with asynchronous clear.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      spi_valid_q <= 1'b0;
    end else begin
      spi_valid_q <= spi_valid_d;
    end
  end

  assign spi_valid = spi_valid_q;
`endif

endmodule : spi_rx16
`default_nettype wire

// File: tb/tb_spi_rx16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_spi_rx16                                                  |
// | Desc   : Directed self-checking bench for spi_rx16.                   |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_spi_rx16;
  import spi_pkg::*;

  logic      spi_clk;
  logic      reset;
  logic      spi_cs;
  logic      spi_mosi;
  spi_word_t spi_data;
`ifdef SPI_RX16_VALID_EN
  logic      spi_valid;
`endif

  int n_cmp;
  int n_err;

  spi_rx16 #(.DATA_W(SPI_WORD_W), .MSB_FIRST(1'b1)) dut (
    .spi_clk  (spi_clk),
    .reset    (reset),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi)
`ifdef SPI_RX16_VALID_EN
    ,
    .spi_valid(spi_valid)
`endif
    ,
    .spi_data (spi_data)
  );

  // Single checking task: every comparison is counted here.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // mosi changes while clk is high, clk falls, then rises; sample 1 after.
  task automatic clk_bit(input logic b);
    spi_mosi = b;
    #5 spi_clk = 1'b0;
    #5 spi_clk = 1'b1;
    #1;
  endtask

  // One full frame, MSB first; checks hold before the last edge and the
  // completed word after it.
  task automatic send_word(input logic [15:0] w, input logic [15:0] prev, input string tag);
    spi_cs = 1'b0;
    for (int i = 0; i < 16; i++) begin
      clk_bit(w[15-i]);
`ifdef SPI_RX16_VALID_EN
      check({tag, "_valid"}, {15'd0, spi_valid}, (i == 15) ? 16'd1 : 16'd0);
`endif
      if (i == 14) check({tag, "_hold"}, spi_data, prev);
    end
    check(tag, spi_data, w);
  endtask

  // Deselect pulse with no clock edge.
  task automatic cs_pulse();
    spi_cs = 1'b1;
    #3;
    spi_cs = 1'b0;
    #2;
  endtask

  logic [15:0] vec [8];
  logic [15:0] prev;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    spi_clk  = 1'b1;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    reset    = 1'b1;
    vec[0] = 16'h0000; vec[1] = 16'h5555; vec[2] = 16'hAAAA; vec[3] = 16'hFFFF;
    vec[4] = 16'h1000; vec[5] = 16'h0001; vec[6] = 16'h1001; vec[7] = 16'hA55A;

    #7;
    check("reset_data", spi_data, 16'h0000);
`ifdef SPI_RX16_VALID_EN
    check("reset_valid", {15'd0, spi_valid}, 16'd0);
`endif
    reset = 1'b0;
    #3;

    // Load a nonzero word, then reset partway through the next frame.
    send_word(16'hBEEF, 16'h0000, "pre_reset");
    cs_pulse();
    for (int i = 0; i < 5; i++) clk_bit(1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_reset", spi_data, 16'h0000);
    #2 reset = 1'b0;
    #2;
    send_word(16'h1001, 16'h0000, "post_reset");
    cs_pulse();

    // Back-to-back frames with chip-select pulses and no idle edges.
    prev = 16'h1001;
    for (int k = 0; k < 8; k++) begin
      send_word(vec[k], prev, $sformatf("b2b%0d", k));
      spi_cs = 1'b1;
      #3;
      check($sformatf("b2b%0d_cs_hi", k), spi_data, vec[k]);
      spi_cs = 1'b0;
      #2;
      prev = vec[k];
    end

    // Partial frame discarded by an edge with chip select high.
    spi_cs = 1'b0;
    for (int i = 0; i < 7; i++) clk_bit(i[0]);
    check("partial_hold", spi_data, 16'hA55A);
    spi_cs = 1'b1;
    clk_bit(1'b1);
    check("partial_cs_edge", spi_data, 16'hA55A);
    send_word(16'h1234, 16'hA55A, "after_partial");
    cs_pulse();

    // Bit ordering.
    send_word(16'h8000, 16'h1234, "msb_word");
    check("msb_bit15", {15'd0, spi_data[15]}, 16'd1);
    check("msb_rest", {1'b0, spi_data[14:0]}, 16'h0000);
    cs_pulse();
    send_word(16'h0001, 16'h8000, "lsb_word");
    check("lsb_bit0", {15'd0, spi_data[0]}, 16'd1);

    // Chip select held high: clocking random data must change nothing.
    spi_cs = 1'b1;
    for (int i = 0; i < 20; i++) clk_bit(1'($urandom_range(0, 1)));
    check("cs_high_idle", spi_data, 16'h0001);
`ifdef SPI_RX16_VALID_EN
    check("cs_high_valid", {15'd0, spi_valid}, 16'd0);
`endif

    // Fresh frame after the idle edges.
    send_word(16'hA55A, 16'h0001, "final");
`ifdef SPI_RX16_VALID_EN
    spi_cs = 1'b1;
    clk_bit(1'b0);
    check("final_valid_drop", {15'd0, spi_valid}, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_rx16
`default_nettype wire
